// File: rtl/alu_muldiv_seq_if.sv
// ----------------------------------------------------------------------------
// alu_muldiv_seq_if
// Bundles the sequencer's request/result handshake and its connection to the
// shared 16-bit combinational ALU.
//   start/op/opa/opb        : operation request from the control unit
//   busy/done               : iteration in progress / one-cycle completion pulse
//   res_hi/res_lo           : product[31:16]/[15:0] or remainder/quotient
//   div_by_zero             : flags a divide whose divisor was zero
//   alu_A/alu_B/alu_ALUOp   : operands and opcode driven into the shared ALU
//   alu_result/alu_carry    : combinational ALU response
// The slave modport is the sequencer; the master modport is its environment
// (control unit plus ALU).
// ----------------------------------------------------------------------------
interface alu_muldiv_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             div_by_zero;
    logic [WIDTH-1:0] alu_A;
    logic [WIDTH-1:0] alu_B;
    logic [1:0]       alu_ALUOp;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;

    modport slave (
        input  start, op, opa, opb, alu_result, alu_carry,
        output busy, done, res_hi, res_lo, div_by_zero, alu_A, alu_B, alu_ALUOp
    );

    modport master (
        output start, op, opa, opb, alu_result, alu_carry,
        input  busy, done, res_hi, res_lo, div_by_zero, alu_A, alu_B, alu_ALUOp
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// ----------------------------------------------------------------------------
// alu_muldiv_seq
// Multi-cycle unsigned 16x16 multiply (shift-add) and 16/16 divide (restoring)
// that borrows the shared combinational ALU for its add/subtract step, one
// iteration per clock, WIDTH iterations per operation.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high; aborts any operation without a done
//   bus    : alu_muldiv_seq_if.slave (request, results, ALU drive/response)
// ----------------------------------------------------------------------------
module alu_muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_muldiv_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state, w_state_nx;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    // r_hi/r_lo hold P_hi/P_lo during multiply and R/Q during divide;
    // r_m holds the multiplicand M or the divisor D.
    logic [WIDTH-1:0] r_hi, w_hi_nx;
    logic [WIDTH-1:0] r_lo, w_lo_nx;
    logic [WIDTH-1:0] r_m, w_m_nx;
    logic [WIDTH-1:0] r_res_hi, r_res_lo;
    logic             r_dbz;

    logic             w_cap;
    logic [WIDTH-1:0] w_cap_hi, w_cap_lo;
    logic             w_cap_dbz;
    logic [WIDTH-1:0] w_alu_a, w_alu_b;
    logic [1:0]       w_alu_op;
    logic [WIDTH-1:0] w_s;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_hi_nx    = r_hi;
        w_lo_nx    = r_lo;
        w_m_nx     = r_m;
        w_cap      = 1'b0;
        w_cap_hi   = r_hi;
        w_cap_lo   = r_lo;
        w_cap_dbz  = 1'b0;
        w_alu_a    = '0;
        w_alu_b    = '0;
        w_alu_op   = 2'b00;
        // Shifted partial remainder for the divide step; its top bit r_hi[MSB]
        // is the 17th bit that the 16-bit ALU compare cannot see.
        w_s        = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};

        case (r_state)
            S_IDLE, S_DONE: begin
                if (r_state == S_DONE) begin
                    w_state_nx = S_IDLE;
                end
                if (bus.start) begin
                    w_cnt_nx = '0;
                    w_hi_nx  = '0;
                    if (!bus.op) begin
                        w_lo_nx    = bus.opb;
                        w_m_nx     = bus.opa;
                        w_state_nx = S_MUL;
                    end else begin
                        w_lo_nx = bus.opa;
                        w_m_nx  = bus.opb;
                        if (bus.opb == '0) begin
                            // Divide by zero completes without iterating.
                            w_state_nx = S_DONE;
                            w_cap      = 1'b1;
                            w_cap_hi   = bus.opa;
                            w_cap_lo   = '1;
                            w_cap_dbz  = 1'b1;
                        end else begin
                            w_state_nx = S_DIV;
                        end
                    end
                end
            end

            S_MUL: begin
                w_alu_a  = r_hi;
                w_alu_b  = r_lo[0] ? r_m : '0;
                w_alu_op = 2'b00;
                w_hi_nx  = {bus.alu_carry, bus.alu_result[WIDTH-1:1]};
                w_lo_nx  = {bus.alu_result[0], r_lo[WIDTH-1:1]};
                w_cnt_nx = r_cnt + 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state_nx = S_DONE;
                    w_cap      = 1'b1;
                    w_cap_hi   = w_hi_nx;
                    w_cap_lo   = w_lo_nx;
                end
            end

            S_DIV: begin
                w_alu_a  = w_s;
                w_alu_b  = r_m;
                w_alu_op = 2'b01;
                if (r_hi[WIDTH-1] | bus.alu_carry) begin
                    w_hi_nx = bus.alu_result;
                    w_lo_nx = {r_lo[WIDTH-2:0], 1'b1};
                end else begin
                    w_hi_nx = w_s;
                    w_lo_nx = {r_lo[WIDTH-2:0], 1'b0};
                end
                w_cnt_nx = r_cnt + 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state_nx = S_DONE;
                    w_cap      = 1'b1;
                    w_cap_hi   = w_hi_nx;
                    w_cap_lo   = w_lo_nx;
                end
            end

            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_dbz    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
            r_m     <= w_m_nx;
            if (w_cap) begin
                r_res_hi <= w_cap_hi;
                r_res_lo <= w_cap_lo;
                r_dbz    <= w_cap_dbz;
            end
        end
    end

    assign bus.busy        = (r_state == S_MUL) || (r_state == S_DIV);
    assign bus.done        = (r_state == S_DONE);
    assign bus.res_hi      = r_res_hi;
    assign bus.res_lo      = r_res_lo;
    assign bus.div_by_zero = r_dbz;
    assign bus.alu_A       = w_alu_a;
    assign bus.alu_B       = w_alu_b;
    assign bus.alu_ALUOp   = w_alu_op;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_muldiv_seq
// Directed bench for alu_muldiv_seq: a table of operations with hand-computed
// results, plus sequences for ignored starts, back-to-back operation and
// mid-operation reset. Includes a behavioural model of the shared ALU.
// ----------------------------------------------------------------------------
module tb_alu_muldiv_seq;
    logic clk;
    logic reset;

    alu_muldiv_seq_if #(.WIDTH(16)) bus ();

    alu_muldiv_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU model: ADD/SUB/AND/OR; sub carry means A >= B unsigned.
    always_comb begin
        bus.alu_result = '0;
        bus.alu_carry  = 1'b0;
        case (bus.alu_ALUOp)
            2'b00: {bus.alu_carry, bus.alu_result} = {1'b0, bus.alu_A} + {1'b0, bus.alu_B};
            2'b01: begin
                bus.alu_result = bus.alu_A - bus.alu_B;
                bus.alu_carry  = (bus.alu_A >= bus.alu_B);
            end
            2'b10: bus.alu_result = bus.alu_A & bus.alu_B;
            default: bus.alu_result = bus.alu_A | bus.alu_B;
        endcase
    end

    typedef struct {
        string       name;
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] hi;
        logic [15:0] lo;
        logic        dbz;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(input string nm, input logic op, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] hi,
                                input logic [15:0] lo, input logic dbz);
        vec_t v;
        v.name = nm; v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dbz = dbz;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Presents a one-cycle start; returns #1 after the accepting edge.
    task automatic start_op(input logic op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for done, counting edges, busy cycles and bad ALU opcodes.
    task automatic wait_done(input logic op, output int cyc, output int busy_n,
                             output int aluop_bad);
        cyc = 0; busy_n = 0; aluop_bad = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) begin
                busy_n++;
                if (bus.alu_ALUOp !== {1'b0, op}) aluop_bad++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc, busy_n, bad;
        start_op(v.op, v.a, v.b);
        wait_done(v.op, cyc, busy_n, bad);
        check({v.name, ".latency"}, cyc, v.dbz ? 0 : 16);
        check({v.name, ".busy_cycles"}, busy_n, v.dbz ? 0 : 16);
        check({v.name, ".aluop"}, bad, 0);
        check({v.name, ".res_hi"}, bus.res_hi, v.hi);
        check({v.name, ".res_lo"}, bus.res_lo, v.lo);
        check({v.name, ".div_by_zero"}, bus.div_by_zero, v.dbz);
        @(posedge clk);
        #1;
        check({v.name, ".done_pulse"}, bus.done, 0);
    endtask

    vec_t vecs[8];

    initial begin
        int cyc, busy_n, bad, seen;
        vecs[0] = mk("mul_1234x5678", 1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0);
        vecs[1] = mk("mul_ffffxffff", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);
        vecs[2] = mk("mul_0000xbeef", 1'b0, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 1'b0);
        vecs[3] = mk("div_1000by7",   1'b1, 16'd1000,  16'd7,    16'h0006, 16'h008E, 1'b0);
        vecs[4] = mk("div_ffffby8001",1'b1, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0);
        vecs[5] = mk("div_5by9",      1'b1, 16'h0005, 16'h0009, 16'h0005, 16'h0000, 1'b0);
        vecs[6] = mk("div_abby0",     1'b1, 16'h00AB, 16'h0000, 16'h00AB, 16'hFFFF, 1'b1);
        vecs[7] = mk("mul_3x5",       1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0);

        bus.start = 1'b0; bus.op = 1'b0; bus.opa = '0; bus.opb = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", bus.busy, 0);
        check("rst.done", bus.done, 0);
        check("rst.res", {bus.res_hi, bus.res_lo}, 32'h0);
        check("rst.dbz", bus.div_by_zero, 0);
        check("rst.alu", {14'h0, bus.alu_ALUOp, bus.alu_A}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Starts presented while busy must not disturb the running multiply.
        start_op(1'b0, 16'h0102, 16'h0304);
        repeat (3) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.op = 1'b1; bus.opa = 16'h00FF; bus.opb = 16'h0000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.op = 1'b0; bus.opa = 16'hFFFF; bus.opb = 16'hFFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(1'b0, cyc, busy_n, bad);
        check("ign.latency", cyc + 9, 16);
        check("ign.res", {bus.res_hi, bus.res_lo}, 32'h0003_0A08);
        check("ign.dbz", bus.div_by_zero, 0);

        // start held high through DONE: a divide follows with no IDLE cycle.
        start_op(1'b0, 16'h0002, 16'h0003);
        bus.start = 1'b1; bus.op = 1'b1; bus.opa = 16'd100; bus.opb = 16'd9;
        wait_done(1'b0, cyc, busy_n, bad);
        check("b2b.first_latency", cyc, 16);
        check("b2b.first_res", {bus.res_hi, bus.res_lo}, 32'h0000_0006);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b.busy_no_idle", bus.busy, 1);
        check("b2b.done_low", bus.done, 0);
        wait_done(1'b1, cyc, busy_n, bad);
        check("b2b.second_latency", cyc, 16);
        check("b2b.second_res", {bus.res_hi, bus.res_lo}, 32'h0001_000B);
        check("b2b.aluop", bad, 0);

        // Reset at iteration 8 aborts the multiply with no done pulse.
        @(posedge clk); #1;
        start_op(1'b0, 16'h1111, 16'h2222);
        repeat (8) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        check("mrst.busy", bus.busy, 0);
        check("mrst.done", bus.done, 0);
        check("mrst.res", {bus.res_hi, bus.res_lo}, 32'h0);
        check("mrst.dbz", bus.div_by_zero, 0);
        check("mrst.alu", {14'h0, bus.alu_ALUOp, bus.alu_A}, 32'h0);
        check("mrst.alu_b", bus.alu_B, 16'h0);
        reset = 1'b0;
        seen = 0;
        repeat (24) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen++;
        end
        check("mrst.no_done", seen, 0);
        run_vec(mk("div_ffffby10", 1'b1, 16'hFFFF, 16'h0010, 16'h000F, 16'h0FFF, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
